// File: rtl/sat_down_itl_top.sv
// ----------------------------------------------------------------------------
// sat_down_itl_top
//
// Frame-buffer interleaver/deinterleaver for the SAT_DOWN link of the VHF
// turbo chain. One serial frame of K = ROWS*C bits is captured, where C is
// taken from link_id on the frame-start edge. The frame is then read back
// one bit position per request cycle. Each read returns three views of the
// frame in parallel:
//   rdata      - natural order             d[j]
//   rdata_itl  - block-interleaved order   d[pi(j)], pi(j) = (j mod 8)*C + j div 8
//   rdata_ditl - deinterleaved order       d[q(j)],  q(j)  = (j mod C)*8 + j div C
//
// Ports:
//   clk        rising-edge clock
//   n_rst      asynchronous active-low reset
//   link_id    frame selector (C); 0 is invalid and ignored
//   din        serial input bit
//   din_vld    frame-start strobe; din in the same cycle is bit 0
//   request    read strobe; one bit position per high cycle
//   rdata, rdata_itl, rdata_ditl  registered read data (0 when not valid)
//   dout_vld   qualifies the three data outputs, one cycle after request
// ----------------------------------------------------------------------------
module sat_down_itl_top #(
    parameter int ROWS = 8,
    parameter int MAXK = 512
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [5:0] link_id,
    input  logic       din,
    input  logic       din_vld,
    input  logic       request,
    output logic       rdata,
    output logic       rdata_itl,
    output logic       rdata_ditl,
    output logic       dout_vld
);

    localparam int AW = $clog2(MAXK);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, WRITE, READY} state_t;

    state_t         state_q, state_d;
    logic [5:0]     c_q, c_d;
    logic [AW-1:0]  k_q, k_d;
    logic [AW-1:0]  wr_i_q, wr_i_d;
    logic [RW-1:0]  wr_row_q, wr_row_d;
    logic [5:0]     wr_col_q, wr_col_d;
    logic [AW-1:0]  wr_pi_q, wr_pi_d;
    logic [AW-1:0]  rd_j_q, rd_j_d;
    logic [RW-1:0]  rd_row_q, rd_row_d;
    logic [5:0]     rd_col_q, rd_col_d;
    logic [AW-1:0]  rd_pi_q, rd_pi_d;
    logic           rdata_q, rdata_d;
    logic           rdata_itl_q, rdata_itl_d;
    logic           rdata_ditl_q, rdata_ditl_d;
    logic           dout_vld_q, dout_vld_d;

    logic           mem_we;
    logic [AW-1:0]  waddr_n;
    logic [AW-1:0]  waddr_d;
    logic           start;

    // memN holds the frame in natural order, memD holds it scattered to
    // pi(i), so a linear read of memD yields the deinterleaved sequence.
    logic           mem_n [MAXK];
    logic           mem_d [MAXK];

    // Advance the running pi address by one position: moving down a row adds
    // C; wrapping past the last row starts the next column at address col+1.
    function automatic void pi_step(
        input  logic [RW-1:0] row,
        input  logic [5:0]    col,
        input  logic [AW-1:0] pi,
        input  logic [5:0]    c,
        output logic [RW-1:0] row_n,
        output logic [5:0]    col_n,
        output logic [AW-1:0] pi_n
    );
        if (row == RW'(ROWS - 1)) begin
            row_n = '0;
            col_n = col + 6'd1;
            pi_n  = AW'(col) + AW'(1);
        end else begin
            row_n = row + RW'(1);
            col_n = col;
            pi_n  = pi + AW'(c);
        end
    endfunction

    assign start = din_vld && (link_id != 6'd0) && (state_q != WRITE);

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        k_d          = k_q;
        wr_i_d       = wr_i_q;
        wr_row_d     = wr_row_q;
        wr_col_d     = wr_col_q;
        wr_pi_d      = wr_pi_q;
        rd_j_d       = rd_j_q;
        rd_row_d     = rd_row_q;
        rd_col_d     = rd_col_q;
        rd_pi_d      = rd_pi_q;
        rdata_d      = 1'b0;
        rdata_itl_d  = 1'b0;
        rdata_ditl_d = 1'b0;
        dout_vld_d   = 1'b0;
        mem_we       = 1'b0;
        waddr_n      = wr_i_q;
        waddr_d      = wr_pi_q;

        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    // Bit 0 lands at address 0 in both arrays; counters are
                    // preloaded for bit 1 (row 1, column 0, pi = C).
                    c_d      = link_id;
                    k_d      = AW'(ROWS) * AW'(link_id);
                    mem_we   = 1'b1;
                    waddr_n  = '0;
                    waddr_d  = '0;
                    wr_i_d   = AW'(1);
                    wr_row_d = RW'(1);
                    wr_col_d = '0;
                    wr_pi_d  = AW'(link_id);
                    rd_j_d   = '0;
                    rd_row_d = '0;
                    rd_col_d = '0;
                    rd_pi_d  = '0;
                    state_d  = WRITE;
                end else if (state_q == READY && request) begin
                    rdata_d      = mem_n[rd_j_q];
                    rdata_itl_d  = mem_n[rd_pi_q];
                    rdata_ditl_d = mem_d[rd_j_q];
                    dout_vld_d   = 1'b1;
                    if (rd_j_q == k_q - AW'(1)) begin
                        rd_j_d   = '0;
                        rd_row_d = '0;
                        rd_col_d = '0;
                        rd_pi_d  = '0;
                    end else begin
                        rd_j_d = rd_j_q + AW'(1);
                        pi_step(rd_row_q, rd_col_q, rd_pi_q, c_q,
                                rd_row_d, rd_col_d, rd_pi_d);
                    end
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                wr_i_d = wr_i_q + AW'(1);
                pi_step(wr_row_q, wr_col_q, wr_pi_q, c_q,
                        wr_row_d, wr_col_d, wr_pi_d);
                if (wr_i_q == k_q - AW'(1)) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            c_q          <= '0;
            k_q          <= '0;
            wr_i_q       <= '0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            wr_pi_q      <= '0;
            rd_j_q       <= '0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            rd_pi_q      <= '0;
            rdata_q      <= 1'b0;
            rdata_itl_q  <= 1'b0;
            rdata_ditl_q <= 1'b0;
            dout_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            k_q          <= k_d;
            wr_i_q       <= wr_i_d;
            wr_row_q     <= wr_row_d;
            wr_col_q     <= wr_col_d;
            wr_pi_q      <= wr_pi_d;
            rd_j_q       <= rd_j_d;
            rd_row_q     <= rd_row_d;
            rd_col_q     <= rd_col_d;
            rd_pi_q      <= rd_pi_d;
            rdata_q      <= rdata_d;
            rdata_itl_q  <= rdata_itl_d;
            rdata_ditl_q <= rdata_ditl_d;
            dout_vld_q   <= dout_vld_d;
        end
    end

    // Frame storage carries no reset; its contents are only read in READY.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_n[waddr_n] <= din;
            mem_d[waddr_d] <= din;
        end
    end

    assign rdata      = rdata_q;
    assign rdata_itl  = rdata_itl_q;
    assign rdata_ditl = rdata_ditl_q;
    assign dout_vld   = dout_vld_q;

endmodule

// File: tb/tb_sat_down_itl_top.sv
// ----------------------------------------------------------------------------
// tb_sat_down_itl_top
//
// Directed sequence of frames and read bursts with randomized frame contents
// and sizes. Expected outputs come from a frame model holding the captured
// bits, C, K and the read position; interleaved and deinterleaved bits are
// indexed directly with the pi/q formulas.
// ----------------------------------------------------------------------------
module tb_sat_down_itl_top;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [5:0] link_id;
    logic       din;
    logic       din_vld;
    logic       request;
    logic       rdata;
    logic       rdata_itl;
    logic       rdata_ditl;
    logic       dout_vld;

    int vectors = 0;
    int miscompares = 0;

    // Frame model
    bit m_ready;
    int m_c;
    int m_k;
    int m_j;
    bit m_d [512];
    bit fbits [512];

    sat_down_itl_top #(.ROWS(8), .MAXK(512)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .link_id    (link_id),
        .din        (din),
        .din_vld    (din_vld),
        .request    (request),
        .rdata      (rdata),
        .rdata_itl  (rdata_itl),
        .rdata_ditl (rdata_ditl),
        .dout_vld   (dout_vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] observed();
        return {dout_vld, rdata, rdata_itl, rdata_ditl};
    endfunction

    function automatic logic [3:0] expected_read();
        int j;
        if (!m_ready) return 4'b0000;
        j = m_j;
        return {1'b1, 1'(m_d[j]), 1'(m_d[(j % 8) * m_c + j / 8]),
                1'(m_d[(j % m_c) * 8 + j / m_c])};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed {vld,d,itl,ditl}=%b expected %b (j=%0d)",
                   tag, obs, exp, m_j);
        end
    endtask

    // Drive one frame of K = 8*c bits from fbits. extra_at > 0 raises
    // din_vld again at that bit; req/chg add requests and link_id noise.
    task automatic send_frame(input int c, input int extra_at, input bit req, input bit chg);
        int k;
        k = 8 * c;
        for (int i = 0; i < k; i++) begin
            din     = fbits[i];
            din_vld = (i == 0) || (i == extra_at);
            request = req;
            if (i == 0) link_id = 6'(c);
            else if (chg) link_id = 6'($urandom_range(0, 63));
            tick();
            chk("write_quiet", observed(), 4'b0000);
        end
        din_vld = 1'b0;
        request = 1'b0;
        din     = 1'b0;
        m_ready = 1'b1;
        m_c     = c;
        m_k     = k;
        m_j     = 0;
        for (int i = 0; i < 512; i++) m_d[i] = fbits[i];
    endtask

    // n consecutive request cycles followed by one idle cycle.
    task automatic read_burst(input int n);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            request = 1'b1;
            e = expected_read();
            tick();
            chk("read", observed(), e);
            if (m_ready) m_j = (m_j + 1) % m_k;
        end
        request = 1'b0;
        tick();
        chk("read_gap", observed(), 4'b0000);
    endtask

    initial begin
        int c;
        n_rst   = 1'b1;
        link_id = 6'd0;
        din     = 1'b0;
        din_vld = 1'b0;
        request = 1'b0;
        m_ready = 1'b0;
        m_c = 1; m_k = 8; m_j = 0;

        // Asynchronous reset: outputs clear before any clock edge.
        #1 n_rst = 1'b0;
        #1 chk("reset", observed(), 4'b0000);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        chk("after_reset", observed(), 4'b0000);

        // Requests in IDLE are dropped.
        read_burst(3);

        // din_vld with link_id = 0 is ignored.
        link_id = 6'd0; din_vld = 1'b1; din = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("vld_id0", observed(), 4'b0000);
        read_burst(3);

        // Alternating frame, K = 256.
        for (int i = 0; i < 512; i++) fbits[i] = (i < 256) ? 1'(i & 1) : 1'b0;
        send_frame(32, 0, 1'b0, 1'b0);
        read_burst(1);
        read_burst(2);
        read_burst(5);
        read_burst(8);
        read_burst(20);

        // din_vld with link_id = 0 in READY keeps the frame and read position.
        link_id = 6'd0; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("ready_id0", observed(), 4'b0000);
        read_burst(4);

        // C = 1: all three views coincide; 16 reads cover a wrap.
        for (int i = 0; i < 512; i++) fbits[i] = 1'($urandom);
        send_frame(1, 0, 1'b0, 1'b0);
        read_burst(16);

        // C = 2, one-hot at bit 1.
        for (int i = 0; i < 512; i++) fbits[i] = (i == 1);
        send_frame(2, 0, 1'b0, 1'b0);
        read_burst(16);

        // Randomized frames with a second din_vld, requests and link_id
        // changes during capture; then reads with wrap-around.
        for (int n = 0; n < 3; n++) begin
            c = (n == 0) ? 63 : $urandom_range(3, 40);
            for (int i = 0; i < 512; i++) fbits[i] = 1'($urandom);
            send_frame(c, $urandom_range(1, 8 * c - 1), 1'b1, 1'b1);
            read_burst($urandom_range(5, 30));
            read_burst(8 * c + $urandom_range(1, 10));
        end

        // New frame in READY restarts reading at j = 0.
        for (int i = 0; i < 512; i++) fbits[i] = 1'($urandom);
        send_frame(5, 0, 1'b0, 1'b0);
        read_burst(7);
        for (int i = 0; i < 512; i++) fbits[i] = 1'($urandom);
        send_frame(3, 0, 1'b0, 1'b0);
        read_burst(30);

        // Reset mid-read.
        request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] e;
            e = expected_read();
            tick();
            chk("pre_reset_read", observed(), e);
            m_j = (m_j + 1) % m_k;
        end
        n_rst = 1'b0;
        #1 chk("reset_mid_read", observed(), 4'b0000);
        m_ready = 1'b0;
        tick();
        n_rst = 1'b1;
        request = 1'b0;
        tick();
        read_burst(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sat_down_itl_top.md
Name: sat_down_itl_top

Overview:
- Frame-buffer interleaver/deinterleaver for the SAT_DOWN link of the VHF turbo chain.
- Captures one serial frame whose length is set by link_id, then returns it one bit per request cycle on three outputs in parallel:
  - natural order,
  - block-interleaved order (8-row row/column permutation),
  - deinterleaved order.
- Sits between the bit source and the turbo encoder/decoder stage.

Parameters:
- ROWS, 8, interleaver row count (fixed; K = ROWS*C).
- MAXK, 512, storage depth in bits (covers K up to 8*63 = 504).

Ports:
- clk  in  1  rising-edge clock
- n_rst  in  1  asynchronous active-low reset
- link_id  in  6  frame selector; C = link_id, K = 8*C; 0 = invalid
- din  in  1  serial input bit
- din_vld  in  1  frame-start strobe; the bit on din in the same cycle is bit 0
- request  in  1  read strobe; each high cycle reads one bit position
- rdata  out  1  natural-order bit d[j]
- rdata_itl  out  1  interleaved bit d[pi(j)], pi(j) = (j mod 8)*C + (j div 8)
- rdata_ditl  out  1  deinterleaved bit d[q(j)], q(j) = (j mod C)*8 + (j div C)
- dout_vld  out  1  qualifies the three data outputs

Behaviour:
- Reset (async, n_rst=0):
  - all outputs 0, state IDLE;
  - write count, read pointer, row/column counters and latched C cleared;
  - storage contents are don't-care.
- States:
  - IDLE: no frame.
  - WRITE: capturing.
  - READY: frame stored, reads allowed.
- Frame start:
  - In IDLE or READY, at an edge with din_vld=1 and link_id!=0: latch C=link_id and K=8*C.
  - Store din as bit 0, set write index i=1 and read pointer j=0, go to WRITE.
  - din_vld with link_id=0 is ignored.
- WRITE:
  - At each subsequent edge, store din as bit i, regardless of din_vld.
  - After bit K-1 is stored, go to READY.
  - din_vld while in WRITE is ignored; it does not restart the frame.
  - link_id changes after the start edge are ignored until the next frame.
- Storage: two MAXK x 1 arrays.
  - memN[i] = d[i].
  - memD[pi(i)] = d[i], computed with running row/column counters (no multiplier needed); hence memD[j] = d[q(j)].
- Read (READY only):
  - At an edge with request=1, register rdata=memN[j], rdata_itl=memN[pi(j)], rdata_ditl=memD[j].
  - Set dout_vld=1 and advance j.
  - Latency: one cycle from the request edge to valid output.
- Idle outputs: with request=0, or outside READY, dout_vld=0 and the data outputs are driven 0.
  - Requests in IDLE or WRITE are dropped; nothing is queued.
- Wrap-around: after j=K-1 the pointer returns to 0, with the pi/q counters reset to row 0, column 0. The frame can be re-read indefinitely.
- A new din_vld in READY overwrites the frame and resets j to 0.
- Reset mid-WRITE or mid-read aborts to IDLE; a new frame start is required.
- Permutation counters:
  - pi(j): row r = j mod 8, column c = j div 8; address = r*C + c, accumulated by adding C per step and wrapping on r = 7.
  - q uses the transposed roles.

Test Plan:
- Alternating frame, full read: reset, link_id=32 (K=256), din_vld pulse with din=0 then 1,0,1,... for 256 bits; 8 request cycles in bursts of 1, 2 and 5.
  - Required: dout_vld high exactly 8 cycles, each one cycle after its request.
  - rdata = 0,1,0,1,0,1,0,1; rdata_itl = eight 0s; rdata_ditl = eight 0s.
  - Continuing reads to j=8..15 give rdata_itl = eight 1s; rdata_ditl turns 1 at j=32.
- Permutation check: link_id=1 (K=8) -> rdata_itl equals rdata, and rdata_ditl equals rdata.
- Permutation check, link_id=2 (K=16), d = one-hot at bit 1:
  - rdata_itl is 1 only at j=8 (pi(8)=1);
  - rdata_ditl is 1 only at j=2 (q(2)=1).
- Wrap and re-read: K=8, 16 consecutive requests -> the output sequence repeats after 8 bits.
- Guards:
  - din_vld with link_id=0 -> no capture, and requests give dout_vld=0.
  - A second din_vld during WRITE does not restart the frame.
  - Requests during WRITE give dout_vld=0.
- Reset mid-read: drop n_rst after 3 reads -> outputs 0 immediately (asynchronous); after release, requests give dout_vld=0 until a new frame is captured.
